// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO deserializer.
//   sipo_state_t : receive FSM state (IDLE between words, SHIFT mid-word)
//   ORD_MSB/LSB  : values of the bit-order select
package sipo_pkg;

  typedef enum logic {IDLE, SHIFT} sipo_state_t;

  localparam logic ORD_MSB = 1'b0;
  localparam logic ORD_LSB = 1'b1;

endpackage

// File: rtl/sipo_shift_stage.sv
// Shift register with selectable direction.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear of the register
//   en         : shift one bit this cycle
//   ord        : ORD_MSB shifts left (sin into bit 0), ORD_LSB shifts right (sin into bit N-1)
//   sin        : serial input bit
//   r          : current register contents
//   r_next     : combinational value the register takes if en is set
module sipo_shift_stage
  import sipo_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         ord,
  input  logic         sin,
  output logic [N-1:0] r,
  output logic [N-1:0] r_next
);

  always_comb begin
    r_next = r;
    if (ord == ORD_LSB) begin
      r_next = {sin, r[N-1:1]};
    end else begin
      r_next = {r[N-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r <= '0;
    end else if (en) begin
      r <= r_next;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles N-bit words from a qualified bit stream,
// delivers them through a valid/ready holding register and flags dropped words.
// Ports:
//   clk, reset : clock, synchronous active-high reset (highest priority)
//   sin        : serial data bit, qualified by sin_valid
//   lsb_first  : bit order, sampled on the first bit of each word
//   clear      : abort the partial word and clear overrun
//   q, q_valid : holding register and its valid flag
//   q_ready    : consumer accepts q when q_valid && q_ready
//   busy       : a word is partially received
//   bit_cnt    : bits received so far in the current word
//   overrun    : sticky, a completed word found the holding register occupied
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sin,
  input  logic          sin_valid,
  input  logic          lsb_first,
  input  logic          clear,
  output logic [N-1:0]  q,
  output logic          q_valid,
  input  logic          q_ready,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun
);

  sipo_state_t   state_q;
  logic          ord_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  q_q;
  logic          q_valid_q;
  logic          overrun_q;

  logic          ord_eff;
  logic          accept;
  logic          last;
  logic          done;
  logic [N-1:0]  r;
  logic [N-1:0]  r_next;

  // The first bit of a word must use the order sampled in that same cycle.
  assign ord_eff = (state_q == IDLE) ? lsb_first : ord_q;
  assign accept  = sin_valid && !clear;
  assign last    = (state_q == SHIFT) && (cnt_q == CW'(N - 1));
  assign done    = accept && last;

  sipo_shift_stage #(
    .N (N)
  ) u_shift (
    .clk    (clk),
    .reset  (reset),
    .clr    (clear),
    .en     (accept),
    .ord    (ord_eff),
    .sin    (sin),
    .r      (r),
    .r_next (r_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ord_q     <= ORD_MSB;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (clear) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        overrun_q <= 1'b0;
      end else if (sin_valid) begin
        unique case (state_q)
          IDLE: begin
            state_q <= SHIFT;
            ord_q   <= lsb_first;
            cnt_q   <= CW'(1);
          end
          SHIFT: begin
            if (last) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        endcase
      end

      // Holding register: a completion may refill it in the same cycle it is consumed.
      if (done) begin
        if (!q_valid_q || q_ready) begin
          q_q       <= r_next;
          q_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (q_valid_q && q_ready) begin
        q_valid_q <= 1'b0;
      end
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = (state_q == SHIFT);
  assign bit_cnt = cnt_q;
  assign overrun = overrun_q;

  logic unused_r;
  assign unused_r = ^r;

endmodule
